// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// State encoding and counter sizing live here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: two half-adder stages
// with the stage carries OR-ed together.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock with a
// registered carry, start/done handshake and result hold.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (clog2(K) < 1) ? 1 : clog2(K);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad
    $fatal(1, "serial_adder: illegal WIDTH/DIGIT");
  end

  state_t state;
  state_t nstate;

  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] snext;
  logic [WIDTH-1:0] dext;
  logic             creg;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   ch;
  logic             last;
  logic             accept;

  assign ch[0] = creg;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder_cell u_fa (
      .a  (areg[i]),
      .b  (breg[i]),
      .ci (ch[i]),
      .s  (dsum[i]),
      .co (ch[i+1])
    );
  end

  // New digit enters the sum shift register from the MSB side.
  assign dext  = WIDTH'(dsum) << (WIDTH - DIGIT);
  assign snext = (sreg >> DIGIT) | dext;
  assign last  = (cnt == CW'(K - 1));

  assign accept = start &&
                  ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (1'b1)
      (state == IDLE): nstate = start ? RUN : IDLE;
      (state == RUN):  nstate = last ? DONE : RUN;
      (state == DONE): nstate = start ? RUN : IDLE;
      default:         nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == RUN):  busy = 1'b1;
      (state == DONE): done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      creg  <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Carry <= 1'b0;
    end else if (accept) begin
      areg <= A;
      breg <= B;
      creg <= Cin;
      sreg <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      areg <= areg >> DIGIT;
      breg <= breg >> DIGIT;
      creg <= ch[DIGIT];
      sreg <= snext;
      cnt  <= cnt + CW'(1);
      if (last) begin
        Sum   <= snext;
        Carry <= ch[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder
// across several WIDTH/DIGIT configurations.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       st [5];
  logic [7:0] a  [5];
  logic [7:0] b  [5];
  logic       ci [5];
  logic       bz [5];
  logic       dn [5];
  logic       cy [5];
  logic [7:0] sm [5];

  int wd [5] = '{8, 8, 4, 4, 4};
  int kk [5] = '{8, 2, 4, 2, 1};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    if (g < 2) begin : g_w8
      serial_adder #(
        .WIDTH (8),
        .DIGIT ((g == 0) ? 1 : 4)
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (st[g]),
        .A     (a[g]),
        .B     (b[g]),
        .Cin   (ci[g]),
        .busy  (bz[g]),
        .done  (dn[g]),
        .Sum   (sm[g]),
        .Carry (cy[g])
      );
    end else begin : g_w4
      logic [3:0] s4;
      serial_adder #(
        .WIDTH (4),
        .DIGIT ((g == 2) ? 1 : ((g == 3) ? 2 : 4))
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (st[g]),
        .A     (a[g][3:0]),
        .B     (b[g][3:0]),
        .Cin   (ci[g]),
        .busy  (bz[g]),
        .done  (dn[g]),
        .Sum   (s4),
        .Carry (cy[g])
      );
      assign sm[g] = {4'h0, s4};
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation; pulse_at>=0 raises start once mid-run.
  task automatic op(input int i,
                    input logic [7:0] av_in,
                    input logic [7:0] bv_in,
                    input logic cv,
                    input int pulse_at);
    logic [7:0] av, bv, es, prev;
    logic [8:0] f;
    logic       ec;
    int         n, nb;
    bit         moved;
    av = (wd[i] == 8) ? av_in : (av_in & 8'h0F);
    bv = (wd[i] == 8) ? bv_in : (bv_in & 8'h0F);
    f  = 9'(av) + 9'(bv) + 9'(cv);
    if (wd[i] == 8) begin
      es = f[7:0];
      ec = f[8];
    end else begin
      es = {4'h0, f[3:0]};
      ec = f[4];
    end
    @(negedge clk);
    st[i] = 1'b1;
    a[i]  = av;
    b[i]  = bv;
    ci[i] = cv;
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    a[i]  = 8'($urandom);
    b[i]  = 8'($urandom);
    ci[i] = 1'($urandom);
    prev  = sm[i];
    n     = 0;
    nb    = 0;
    moved = 0;
    while (!dn[i] && n < 40) begin
      nb += int'(bz[i]);
      if (sm[i] !== prev) moved = 1;
      if (n == pulse_at) begin
        st[i] = 1'b1;
        a[i]  = ~av;
        b[i]  = ~bv;
      end else begin
        st[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    st[i] = 1'b0;
    check("latency", n, kk[i]);
    check("busy_cycles", nb, kk[i]);
    check("busy_at_done", bz[i], 0);
    check("sum_hold", moved, 0);
    check("sum", sm[i], es);
    check("carry", cy[i], ec);
    @(posedge clk);
    #1;
    check("done_width", dn[i], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, nd;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      st[i] = 1'b0;
      a[i]  = '0;
      b[i]  = '0;
      ci[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 5; i++) begin
      check("rst_busy", bz[i], 0);
      check("rst_done", dn[i], 0);
      check("rst_sum", sm[i], 0);
      check("rst_carry", cy[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    op(0, 8'hFF, 8'h01, 1'b0, -1);
    op(1, 8'h3C, 8'hA5, 1'b1, -1);

    // start held high across two operations
    @(negedge clk);
    st[0] = 1'b1;
    a[0]  = 8'h80;
    b[0]  = 8'h80;
    ci[0] = 1'b0;
    @(posedge clk);
    #1;
    a[0] = 8'h0F;
    b[0] = 8'h01;
    n = 0;
    while (!dn[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_lat1", n, 8);
    check("b2b_sum1", sm[0], 8'h00);
    check("b2b_carry1", cy[0], 1);
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    n2 = 1;
    while (!dn[0] && n2 < 40) begin
      @(posedge clk);
      #1;
      n2++;
    end
    check("b2b_gap", n2, 9);
    check("b2b_sum2", sm[0], 8'h10);
    check("b2b_carry2", cy[0], 0);
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of a run
    @(negedge clk);
    st[0] = 1'b1;
    a[0]  = 8'hFF;
    b[0]  = 8'h01;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", bz[0], 1);
    check("pre_rst_sum", sm[0], 8'h10);
    rst = 1'b1;
    #1;
    check("arst_busy", bz[0], 0);
    check("arst_done", dn[0], 0);
    check("arst_sum", sm[0], 0);
    check("arst_carry", cy[0], 0);
    @(negedge clk);
    rst = 1'b0;
    op(0, 8'h5A, 8'hC3, 1'b1, -1);

    // start during RUN must be ignored
    op(0, 8'h12, 8'h34, 1'b0, 3);
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      nd += int'(dn[0]);
    end
    check("ignored_start_done", nd, 0);
    op(1, 8'h77, 8'h99, 1'b0, 0);

    repeat (40) begin
      op(0, 8'($urandom), 8'($urandom), 1'($urandom), -1);
      op(1, 8'($urandom), 8'($urandom), 1'($urandom), -1);
    end

    for (int i = 2; i < 5; i++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          for (int c = 0; c < 2; c++)
            op(i, 8'(x), 8'(y), 1'(c), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that computes `A + B + Cin` over `WIDTH` bits, `DIGIT` bits per clock, using a registered carry between digits. It extends the dataflow half-adder with a start/done handshake, operand latching, a result hold register and a carry-in. It serves as the area-lean arithmetic primitive for datapaths where single-cycle ripple width is too costly.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; must be ≥ 1 and an integer multiple of `DIGIT`.
- `DIGIT`, default 1: bits added per cycle; must be ≥ 1 and ≤ `WIDTH`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `start` input 1: request; sampled on `clk` rising edge.
- `A` input `WIDTH`: operand A; sampled only when `start` is accepted.
- `B` input `WIDTH`: operand B; sampled only when `start` is accepted.
- `Cin` input 1: carry-in; sampled only when `start` is accepted.
- `busy` output 1: high while a computation is running.
- `done` output 1: one-cycle pulse marking a new valid result.
- `Sum` output `WIDTH`: last completed sum; holds between completions.
- `Carry` output 1: last completed carry-out; holds between completions.

## Operation
- Number of digit steps: `K = WIDTH/DIGIT`. Counter width is `clog2(K)`, with a minimum of 1 bit.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → latch `A`, `B` and `Cin` into internal shift registers; clear the counter; go to RUN. `start`=0 → stay in IDLE.
  - RUN: each cycle, add the low `DIGIT` bits of the A and B shift registers plus the carry register.
    - The `DIGIT`-bit result shifts into the sum shift register from the MSB side.
    - The new carry is stored in the carry register.
    - The A and B shift registers shift right by `DIGIT`.
    - The counter increments.
    - On the step where the counter reaches `K-1`: load `Sum` from the completed shift value, load `Carry` from the final carry, and go to DONE.
  - DONE: `done`=1 for this cycle only.
    - `start`=1 → accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
    - `start`=0 → go to IDLE.
- `start` in RUN is ignored and is not queued.
- Output values by state:
  - `busy` = 1 in RUN, 0 otherwise.
  - `done` = 1 in DONE only.
- `Sum` and `Carry` change only on the completion edge. They never show partial results.
- Arithmetic is modulo 2^`WIDTH`. `Carry` is bit `WIDTH` of the true sum `A+B+Cin`.
- Reset: asserting `rst` at any time, including mid-RUN, forces the following immediately and without waiting for a clock edge:
  - state = IDLE
  - `busy` = 0, `done` = 0
  - `Sum` = 0, `Carry` = 0
  - counter, shift registers and carry register = 0
  - Any in-flight operation is discarded.
  - After release, the first `start` is accepted on the first rising edge at which `rst` is low.

## Timing
- Start accepted at edge t:
  - `busy`=1 from t to t+K.
  - `Sum`/`Carry` update at edge t+K.
  - `done`=1 from t+K to t+K+1.
- Latency from start to done is K cycles. Throughput is one result per K+1 cycles when `start` is held high.
- `DIGIT`=`WIDTH` (K=1): RUN lasts one cycle; `done` follows 1 cycle after `start`.
- Operand inputs may change freely after the accepting edge.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- Shared package `serial_adder_pkg` contains:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a `clog2` constant function used for counter sizing.
- Sub-module `full_adder_cell`: a 1-bit full adder built from two half-adder stages plus an OR of the two carries.
  - It is instantiated `DIGIT` times as a carry-chained generate loop.
  - The carry into bit 0 is the carry register.
- Parameter legality (`WIDTH % DIGIT == 0`) is checked at elaboration; violation is a fatal error.

## Test plan
- `WIDTH`=8, `DIGIT`=1; `A`=8'hFF, `B`=8'h01, `Cin`=0 → `Sum`=8'h00 and `Carry`=1. `done` pulses 8 cycles after the accepting edge; `busy` is high for exactly 8 cycles.
- `WIDTH`=8, `DIGIT`=4; `A`=8'h3C, `B`=8'hA5, `Cin`=1 → `Sum`=8'hE2 and `Carry`=0 after 2 cycles. `Sum` holds its previous value until the completion edge.
- `start` held high, `WIDTH`=8, `DIGIT`=1, with operand pairs (8'h80, 8'h80, 0) then (8'h0F, 8'h01, 0):
  - results are {`Sum`=8'h00, `Carry`=1} then {`Sum`=8'h10, `Carry`=0};
  - the two `done` pulses are 9 cycles apart.
- Reset mid-RUN: assert `rst` 3 cycles into an 8-cycle operation, asynchronously between clock edges → `busy`, `done`, `Sum` and `Carry` become 0 before the next edge. After release, a new `start` completes correctly.
- `start` pulsed during RUN with different operands → ignored; the result matches the original operands, and exactly one `done` pulse occurs.
- Exhaustive check for `WIDTH`=4 with `DIGIT` = 1, 2 and 4: all 512 combinations of (`A`, `B`, `Cin`) → {`Carry`,`Sum`} == `A`+`B`+`Cin`, and `done` latency equals `WIDTH/DIGIT`.
